// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: data width, FSM encoding
// and statistics counter width.
package fifo_wr_arbiter_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int ARB_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector (rr_pick): one-hot grant to the first
// requester after last_gnt, wrapping modulo NUM_REQ.
module fifo_wr_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional statistics counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = fifo_wr_arbiter_pkg::FIFO_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                arb_en,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic                                fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]               fifo_data_in,
  input  logic                                fifo_full,
  input  logic                                fifo_almostfull,
  input  logic                                fifo_wr_ack,
  input  logic                                fifo_overflow,
  output logic [1:0]                          arb_state,
  output logic                                err
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][fifo_wr_arbiter_pkg::ARB_CNT_W-1:0] grant_cnt,
  output logic [fifo_wr_arbiter_pkg::ARB_CNT_W-1:0]              stall_cnt
`endif
);

  import fifo_wr_arbiter_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  ok;
  logic                  xfer;
  logic [IDX_W-1:0]      last_gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic [FIFO_WIDTH-1:0] sel_data;
  logic                  ack_pend;
  arb_state_e            state_q, state_d;

  // A write already on the pins while almostfull may fill the FIFO, so hold off.
  assign ok   = arb_en && !fifo_full && !(fifo_almostfull && fifo_wr_en);
  assign xfer = |(req & gnt);

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .enable   (ok && rst_n),
    .gnt      (gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = IDX_W'(i);
        sel_data = req_data[i];
      end
    end
  end

  // Transfer edge -> registered write at the FIFO pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt     <= IDX_W'(NUM_REQ - 1);
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) begin
        last_gnt     <= gnt_idx;
        fifo_data_in <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (xfer)                       state_d = ISSUE;
    else if (|req && arb_en && !ok) state_d = STALL;
  end

  assign arb_state = state_q;

  // Ack check: a write on the pins in cycle t must be acknowledged in t+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack_pend <= fifo_wr_en;
      if ((ack_pend && !fifo_wr_ack) || fifo_overflow) err <= 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && gnt[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
      if (state_q == STALL) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter driving a depth-8 FIFO model.
// Covers FIFO_ARB_STATS_EN counters when that macro is defined.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                arb_en;
  logic [N-1:0]        req;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]        gnt;
  logic                fifo_wr_en;
  logic [W-1:0]        fifo_data_in;
  logic                fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic [1:0]          arb_state;
  logic                err;
`ifdef FIFO_ARB_STATS_EN
  logic [N-1:0][15:0]  grant_cnt;
  logic [15:0]         stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arb_en          (arb_en),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .arb_state       (arb_state),
    .err             (err)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt       (grant_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  // Depth-8 synchronous FIFO model (occupancy and flags only)
  logic       rd_en, force_nack, force_ovf;
  logic [3:0] cnt;
  logic       ack_q, ovf_q, do_wr, do_rd;

  assign do_wr           = fifo_wr_en && (cnt != 4'd8);
  assign do_rd           = rd_en && (cnt != 4'd0);
  assign fifo_full       = (cnt == 4'd8);
  assign fifo_almostfull = (cnt == 4'd7);
  assign fifo_wr_ack     = ack_q && !force_nack;
  assign fifo_overflow   = ovf_q || force_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 4'd0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt   <= cnt + 4'(do_wr) - 4'(do_rd);
      ack_q <= do_wr;
      ovf_q <= fifo_wr_en && !do_wr;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write presented at the FIFO pins is matched to the scoreboard
  always @(negedge clk) begin
    if (rst_n && fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h, required no write", fifo_data_in);
      end else begin
        chk("write_data", 32'(fifo_data_in), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arb_en = 1'b1; req = '1; req_data = '0;
    rd_en = 1'b1; force_nack = 1'b0; force_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",   32'(gnt), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data",  32'(fifo_data_in), 32'd0);
    chk("rst_state", 32'(arb_state), 32'd0);
    chk("rst_err",   32'(err), 32'd0);

    // Single write
    @(posedge clk); #1 rst_n = 1'b1; req = 4'b0001; req_data[0] = 16'hA5A5;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_state_idle0", 32'(arb_state), 32'd0);
    exp_q.push_back(16'hA5A5);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("t1_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t1_state_issue", 32'(arb_state), 32'd1);
    @(negedge clk);
    chk("t1_state_idle", 32'(arb_state), 32'd0);
    chk("t1_wr_en_off", 32'(fifo_wr_en), 32'd0);
    @(negedge clk);
    chk("t1_err", 32'(err), 32'd0);

    // Round robin, FIFO drained every cycle
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i] = 16'hB000 + 16'(i);
    for (int c = 0; c < 8; c++) exp_q.push_back(16'hB000 + 16'(c % 4));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t2_gnt", 32'(gnt), 32'(1 << (c % 4)));
      @(posedge clk); #1;
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("t2_err", 32'(err), 32'd0);

    // Fill the FIFO with no reads
    rd_en = 1'b0;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i] = 16'hC000 + 16'(i);
    for (int c = 0; c < 8; c++) exp_q.push_back(16'hC000 + 16'(c % 4));
    repeat (14) @(negedge clk);
    chk("t3_gnt", 32'(gnt), 32'd0);
    chk("t3_state", 32'(arb_state), 32'd2);
    chk("t3_level", 32'(cnt), 32'd8);
    chk("t3_ovf", 32'(fifo_overflow), 32'd0);
    chk("t3_err", 32'(err), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    chk("t3_grant_cnt0", 32'(grant_cnt[0]), 32'd2);
    chk("t3_grant_cnt3", 32'(grant_cnt[3]), 32'd2);
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd4);
`endif

    // One read from full -> exactly one more write
    exp_q.push_back(16'hC000);
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_level", 32'(cnt), 32'd8);
    chk("t4_gnt", 32'(gnt), 32'd0);
    chk("t4_state", 32'(arb_state), 32'd2);
    chk("t4_err", 32'(err), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    chk("t4_grant_cnt0", 32'(grant_cnt[0]), 32'd3);
`endif

    // Missing ack
    req = '0; rd_en = 1'b1; force_nack = 1'b1;
    do_reset();
    req = 4'b0001; req_data[0] = 16'hD000;
    exp_q.push_back(16'hD000);
    @(negedge clk);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("t5_err_c1", 32'(err), 32'd0);
    @(negedge clk);
    chk("t5_err_c2", 32'(err), 32'd0);
    @(negedge clk);
    chk("t5_err_set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_err_hold", 32'(err), 32'd1);
    force_nack = 1'b0;
    do_reset();
    @(negedge clk);
    chk("t5_err_clr", 32'(err), 32'd0);

    // Overflow flag
    @(posedge clk); #1 force_ovf = 1'b1;
    @(negedge clk);
    chk("t5b_err_pre", 32'(err), 32'd0);
    @(posedge clk); #1 force_ovf = 1'b0;
    @(negedge clk);
    chk("t5b_err_set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    chk("t5b_err_hold", 32'(err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("t5b_err_clr", 32'(err), 32'd0);

    // Reset right after a transfer
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i] = 16'hE000 + 16'(i);
    @(negedge clk);
    chk("t6_gnt_pre", 32'(gnt), 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t6_data", 32'(fifo_data_in), 32'd0);
    chk("t6_gnt_rst", 32'(gnt), 32'd0);
    chk("t6_state", 32'(arb_state), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_gnt_post", 32'(gnt), 32'h1);
    exp_q.push_back(16'hE000);
    @(posedge clk); #1 req = '0;
    repeat (3) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
